store_merge_unit: RTL and testbench

Store-side counterpart of the load path's 16->32 sign/zero extender. It truncates a 32-bit register value to byte, half or word width and inserts it into the correct lanes of a 32-bit word in a word-wide synchronous data RAM that has no byte enables. Byte and half stores use a read-modify-write sequence; word stores are written directly. It sits between the MEM stage and the data RAM.

---
 rtl/store_merge_unit_pkg.sv | 60 ++++++
 rtl/store_merge_unit_lane_merge.sv | 15 +
 rtl/store_merge_unit.sv | 145 ++++++++++++++
 tb/tb_store_merge_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/store_merge_unit_pkg.sv
// Shared definitions for the store merge path: size codes, FSM states and
// the lane-merge / alignment helpers used by the merge unit and its sub-block.
package store_merge_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    // Illegal size or an address not aligned to the access width
    function automatic logic is_bad_request(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Little-endian insert of the truncated store data into old_word
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] word;
        word = old_word;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    word[7:0]   = data[7:0];
                    2'd1:    word[15:8]  = data[7:0];
                    2'd2:    word[23:16] = data[7:0];
                    2'd3:    word[31:24] = data[7:0];
                    default: word = old_word;
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    word[31:16] = data[15:0];
                end else begin
                    word[15:0] = data[15:0];
                end
            end
            SZ_WORD: word = data;
            default: word = old_word;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// Combinational lane merge: replaces the addressed byte/half of old_word
// with the low bits of data, preserving all other bits.
module store_lane_merge
    import store_merge_unit_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] new_word
);

    assign new_word = lane_merge(old_word, data, size, lane);

endmodule

// File: rtl/store_merge_unit.sv
// Store path to a word-wide RAM without byte enables: word stores write
// directly, byte/half stores read-modify-write through store_lane_merge.
module store_merge_unit
    import store_merge_unit_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        size,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    state_t              state_r;
    state_t              state_next_s;
    logic [MEM_AW+1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic [1:0]          size_r;
    logic                capture_s;

    logic                req_ready_r;
    logic [MEM_AW-1:0]   mem_addr_r;
    logic                mem_rd_en_r;
    logic                mem_wr_en_r;
    logic [31:0]         mem_wdata_r;
    logic                done_r;
    logic                err_r;

    logic [MEM_AW-1:0]   mem_addr_next_s;
    logic                mem_rd_en_next_s;
    logic                mem_wr_en_next_s;
    logic [31:0]         mem_wdata_next_s;
    logic                done_next_s;
    logic                err_next_s;
    logic [31:0]         merged_s;
    logic                unused_s;

    // Address bits above the RAM's word range do not select anything
    assign unused_s  = &{1'b0, addr[31:MEM_AW+2]};
    assign capture_s = req_valid && (state_r == ST_IDLE);

    store_lane_merge u_lane_merge (
        .old_word (mem_rdata),
        .data     (wdata_r),
        .size     (size_r),
        .lane     (addr_r[1:0]),
        .new_word (merged_s)
    );

    // Next state plus next values of every registered output
    always_comb begin
        state_next_s     = state_r;
        mem_addr_next_s  = '0;
        mem_rd_en_next_s = 1'b0;
        mem_wr_en_next_s = 1'b0;
        mem_wdata_next_s = 32'h0000_0000;
        done_next_s      = 1'b0;
        err_next_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!req_valid) begin
                    state_next_s = ST_IDLE;
                end else if (is_bad_request(size, addr[1:0])) begin
                    state_next_s = ST_ERROR;
                    done_next_s  = 1'b1;
                    err_next_s   = 1'b1;
                end else if (size == SZ_WORD) begin
                    state_next_s     = ST_WRITE;
                    mem_addr_next_s  = addr[MEM_AW+1:2];
                    mem_wr_en_next_s = 1'b1;
                    mem_wdata_next_s = wdata;
                    done_next_s      = 1'b1;
                end else begin
                    state_next_s     = ST_READ;
                    mem_addr_next_s  = addr[MEM_AW+1:2];
                    mem_rd_en_next_s = 1'b1;
                end
            end
            ST_READ: begin
                state_next_s = ST_MERGE;
            end
            // RAM data is valid now; the merged word is registered straight into mem_wdata
            ST_MERGE: begin
                state_next_s     = ST_WRITE;
                mem_addr_next_s  = addr_r[MEM_AW+1:2];
                mem_wr_en_next_s = 1'b1;
                mem_wdata_next_s = merged_s;
                done_next_s      = 1'b1;
            end
            ST_WRITE: state_next_s = ST_IDLE;
            ST_ERROR: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State, captured request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            size_r      <= 2'b00;
            req_ready_r <= 1'b1;
            mem_addr_r  <= '0;
            mem_rd_en_r <= 1'b0;
            mem_wr_en_r <= 1'b0;
            mem_wdata_r <= 32'h0000_0000;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= (state_next_s == ST_IDLE);
            mem_addr_r  <= mem_addr_next_s;
            mem_rd_en_r <= mem_rd_en_next_s;
            mem_wr_en_r <= mem_wr_en_next_s;
            mem_wdata_r <= mem_wdata_next_s;
            done_r      <= done_next_s;
            err_r       <= err_next_s;
            if (capture_s) begin
                addr_r  <= addr[MEM_AW+1:0];
                wdata_r <= wdata;
                size_r  <= size;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign mem_addr  = mem_addr_r;
    assign mem_rd_en = mem_rd_en_r;
    assign mem_wr_en = mem_wr_en_r;
    assign mem_wdata = mem_wdata_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit: directed scenarios plus random
// stores against a word-array reference of the RAM.
module tb_store_merge_unit;

    localparam int MEM_AW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [1:0]        size;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              err;

    logic [31:0] ram     [0:(1<<MEM_AW)-1];
    logic [31:0] ref_mem [0:15];
    int n_vec = 0;
    int n_err = 0;

    store_merge_unit #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .wdata(wdata), .size(size), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous word RAM, one-cycle read latency
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [31:0] a);
        int sh;
        case (sz)
            2'b00: begin
                sh = 8 * int'(a[1:0]);
                return (old & ~(32'h0000_00FF << sh)) | ((d & 32'h0000_00FF) << sh);
            end
            2'b01: begin
                sh = 16 * int'(a[1]);
                return (old & ~(32'h0000_FFFF << sh)) | ((d & 32'h0000_FFFF) << sh);
            end
            2'b10:   return d;
            default: return old;
        endcase
    endfunction

    task automatic set_word(input int idx, input logic [31:0] v);
        ram[idx]     = v;
        ref_mem[idx] = v;
    endtask

    // One store from accept to the cycle after done; optionally keeps req_valid
    // high with the next request presented while the unit is busy.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                            input bit hold, input logic [31:0] na, input logic [31:0] nd,
                            input logic [1:0] nsz);
        bit          bad;
        int          lat;
        int          widx;
        logic [31:0] new_word;
        bit          exp_rd, exp_wr;
        bad  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        lat  = (bad || sz == 2'b10) ? 1 : 3;
        widx = int'(a[11:2]);
        new_word = ref_store(ref_mem[widx], d, sz, a);

        @(negedge clk);
        check_value("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1; addr = a; wdata = d; size = sz;
        @(posedge clk); #1;
        if (hold) begin
            addr = na; wdata = nd; size = nsz;
        end else begin
            req_valid = 1'b0; addr = $urandom; wdata = $urandom; size = 2'($urandom_range(0, 3));
        end
        for (int cyc = 1; cyc <= lat; cyc++) begin
            exp_rd = !bad && sz != 2'b10 && cyc == 1;
            exp_wr = !bad && cyc == lat;
            check_value("ready_busy", 32'(req_ready), 32'd0);
            check_value("rd_en", 32'(mem_rd_en), 32'(exp_rd));
            check_value("wr_en", 32'(mem_wr_en), 32'(exp_wr));
            check_value("done", 32'(done), 32'(cyc == lat));
            check_value("err", 32'(err), 32'(bad && cyc == lat));
            check_value("wdata", mem_wdata, exp_wr ? new_word : 32'h0);
            if (exp_rd || exp_wr) check_value("mem_addr", 32'(mem_addr), 32'(widx));
            if (cyc < lat) begin
                @(posedge clk); #1;
            end
        end
        if (!bad) ref_mem[widx] = new_word;
        @(posedge clk); #1;
        check_value("ready_after", 32'(req_ready), 32'd1);
        check_value("done_after", 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [1:0]  sz;
        rst = 1'b1; req_valid = 1'b0; addr = 32'h0; wdata = 32'h0; size = 2'b00;
        for (int i = 0; i < (1 << MEM_AW); i++) ram[i] = 32'h0;
        for (int i = 0; i < 16; i++) set_word(i, $urandom);
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_ready", 32'(req_ready), 32'd1);
        check_value("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check_value("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_err", 32'(err), 32'd0);
        check_value("rst_wdata", mem_wdata, 32'h0);
        check_value("rst_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;

        set_word(1, 32'h1122_3344);
        do_store(32'h0000_0005, 32'hFFFF_FFAB, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00);
        set_word(1, 32'h1122_3344);
        do_store(32'h0000_0006, 32'h0000_FC57, 2'b01, 1'b0, 32'h0, 32'h0, 2'b00);
        do_store(32'h0000_0008, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 32'h0, 2'b00);
        do_store(32'h0000_0003, 32'h1234_5678, 2'b01, 1'b0, 32'h0, 32'h0, 2'b00);
        do_store(32'h0000_0000, 32'h1234_5678, 2'b11, 1'b0, 32'h0, 32'h0, 2'b00);

        // Reset during MERGE abandons the byte store
        set_word(1, 32'h1122_3344);
        @(negedge clk);
        req_valid = 1'b1; addr = 32'h5; wdata = 32'hFFFF_FFAB; size = 2'b00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_value("abort_rd_en", 32'(mem_rd_en), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_value("abort_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_value("abort_wr_en", 32'(mem_wr_en), 32'd0);
            check_value("abort_done", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        check_value("abort_ram", ram[1], 32'h1122_3344);

        // Back-to-back queued requests with req_valid held high
        set_word(1, 32'h1122_3344);
        d = $urandom;
        do_store(32'h0000_0004, 32'h0000_0077, 2'b00, 1'b1, 32'h0000_000C, d, 2'b10);
        do_store(32'h0000_000C, d, 2'b10, 1'b0, 32'h0, 32'h0, 2'b00);
        check_value("queued_w1", ram[1], 32'h1122_3377);
        check_value("queued_w3", ram[3], d);

        for (int n = 0; n < 150; n++) begin
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            d  = $urandom;
            sz = 2'($urandom_range(0, 3));
            do_store(a, d, sz, 1'b0, 32'h0, 32'h0, 2'b00);
        end

        for (int i = 0; i < 16; i++) check_value("final_ram", ram[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
